// File: rtl/adc_channel_averager_if.sv
// Sample-in / averaged-result-out bundle for adc_channel_averager.
// The averager takes the slave side; the producer/consumer the master side.
interface adc_channel_averager_if;
    logic [7:0] datain;
    logic [2:0] add;
    logic       sample_valid;
    logic [7:0] avg_data;
    logic [2:0] avg_ch;
    logic       avg_valid;
    logic       avg_ready;
    logic       overflow;
    logic       bad_ch;
    logic       flag_clr;

    modport master (
        output datain, add, sample_valid, avg_ready, flag_clr,
        input  avg_data, avg_ch, avg_valid, overflow, bad_ch
    );

    modport slave (
        input  datain, add, sample_valid, avg_ready, flag_clr,
        output avg_data, avg_ch, avg_valid, overflow, bad_ch
    );
endinterface

// File: rtl/adc_channel_averager.sv
// Per-channel 2^AVG_LOG2 sample averager with a FWFT result FIFO.
// Define AVG_ROUND_EN for round-half-up results instead of truncation.
module adc_channel_averager #(
    parameter int CHANNELS   = 4,
    parameter int AVG_LOG2   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic CLK,
    input logic RST,
    adc_channel_averager_if.slave bus
);
    localparam int AW = 8 + AVG_LOG2;
    localparam int SW = 9 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
`ifdef AVG_ROUND_EN
    localparam logic [SW-1:0] RND = SW'((1 << AVG_LOG2) >> 1);
`else
    localparam logic [SW-1:0] RND = '0;
`endif

    logic [AW-1:0] acc [CHANNELS];
    logic [CW-1:0] cnt [CHANNELS];
    logic [10:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic          ch_ok;
    logic          accept;
    logic [AW-1:0] acc_sel;
    logic [CW-1:0] cnt_sel;
    logic          last;
    logic [SW-1:0] sum;
    logic [7:0]    result;
    logic          push;
    logic          full;
    logic          pop;
    logic          push_ok;

    always_comb begin
        ch_ok   = {1'b0, bus.add} < 4'(CHANNELS);
        accept  = bus.sample_valid && ch_ok;
        acc_sel = '0;
        cnt_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.add == 3'(c)) begin
                acc_sel = acc[c];
                cnt_sel = cnt[c];
            end
        end
        last    = cnt_sel == CNT_LAST;
        sum     = SW'(acc_sel) + SW'(bus.datain) + RND;
        result  = 8'(sum >> AVG_LOG2);
        push    = accept && last;
        full    = count == (PW+1)'(FIFO_DEPTH);
        pop     = (count != '0) && bus.avg_ready;
        push_ok = push && (!full || pop);
    end

    assign bus.avg_valid = count != '0;
    assign {bus.avg_ch, bus.avg_data} = mem[rd_ptr];

    // Window completion clears the channel even if the result is dropped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
        end else if (accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (bus.add == 3'(c)) begin
                    if (last) begin
                        acc[c] <= '0;
                        cnt[c] <= '0;
                    end else begin
                        acc[c] <= acc[c] + AW'(bus.datain);
                        cnt[c] <= cnt[c] + CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {bus.add, result};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !push_ok) begin
                count <= count - (PW+1)'(1);
            end
        end
    end

    // Set beats clear when both land on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.overflow <= 1'b0;
            bus.bad_ch   <= 1'b0;
        end else begin
            if (push && full && !pop) begin
                bus.overflow <= 1'b1;
            end else if (bus.flag_clr) begin
                bus.overflow <= 1'b0;
            end
            if (bus.sample_valid && !ch_ok) begin
                bus.bad_ch <= 1'b1;
            end else if (bus.flag_clr) begin
                bus.bad_ch <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adc_channel_averager.sv
// Directed bench for adc_channel_averager at default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_adc_channel_averager;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef AVG_ROUND_EN
    localparam int E_T1 = 12;
    localparam int E_OV = 9;
`else
    localparam int E_T1 = 11;
    localparam int E_OV = 8;
`endif

    adc_channel_averager_if bus ();

    adc_channel_averager dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [2:0] ch, input logic [7:0] d);
        bus.sample_valid = 1'b1;
        bus.add          = ch;
        bus.datain       = d;
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask

    task automatic window(input logic [2:0] ch, input logic [7:0] d);
        for (int i = 0; i < 4; i++) put(ch, d);
    endtask

    task automatic head(input string tag, input int ch, input int d);
        check({tag, "_valid"}, int'(bus.avg_valid), 1);
        check({tag, "_ch"}, int'(bus.avg_ch), ch);
        check({tag, "_data"}, int'(bus.avg_data), d);
    endtask

    task automatic pop_one();
        bus.avg_ready = 1'b1;
        @(negedge clk);
        bus.avg_ready = 1'b0;
    endtask

    initial begin
        bus.datain       = '0;
        bus.add          = '0;
        bus.sample_valid = 1'b0;
        bus.avg_ready    = 1'b0;
        bus.flag_clr     = 1'b0;
        @(negedge clk);
        check("rst_valid", int'(bus.avg_valid), 0);
        check("rst_data", int'(bus.avg_data), 0);
        check("rst_ch", int'(bus.avg_ch), 0);
        check("rst_ovf", int'(bus.overflow), 0);
        check("rst_bad", int'(bus.bad_ch), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // basic average, one-cycle valid with ready held high
        bus.avg_ready = 1'b1;
        put(0, 10); put(0, 11); put(0, 12);
        check("t1_partial", int'(bus.avg_valid), 0);
        put(0, 13);
        head("t1", 0, E_T1);
        @(negedge clk);
        check("t1_popped", int'(bus.avg_valid), 0);
        bus.avg_ready = 1'b0;

        // interleaved channels
        for (int i = 0; i < 4; i++) begin
            put(1, 255);
            put(2, (i == 3) ? 8'd4 : 8'd0);
        end
        head("t2a", 1, 255);
        pop_one();
        head("t2b", 2, 1);
        pop_one();
        check("t2_empty", int'(bus.avg_valid), 0);

        // overflow: fifth window dropped
        window(0, 16);
        window(1, 32);
        window(2, 48);
        window(3, 64);
        check("t3_ovf_pre", int'(bus.overflow), 0);
        window(0, 80);
        check("t3_ovf", int'(bus.overflow), 1);
        head("t3a", 0, 16); pop_one();
        head("t3b", 1, 32); pop_one();
        head("t3c", 2, 48); pop_one();
        head("t3d", 3, 64); pop_one();
        check("t3_empty", int'(bus.avg_valid), 0);
        put(0, 7); put(0, 8); put(0, 9); put(0, 10);
        head("t3e", 0, E_OV);
        pop_one();
        check("t3_ovf_hold", int'(bus.overflow), 1);
        bus.flag_clr = 1'b1;
        @(negedge clk);
        bus.flag_clr = 1'b0;
        check("t3_ovf_clr", int'(bus.overflow), 0);

        // full FIFO with simultaneous push and pop
        window(0, 40);
        window(1, 41);
        window(2, 42);
        window(3, 43);
        put(0, 50); put(0, 50); put(0, 50);
        bus.avg_ready = 1'b1;
        put(0, 50);
        bus.avg_ready = 1'b0;
        check("t4_ovf", int'(bus.overflow), 0);
        head("t4a", 1, 41); pop_one();
        head("t4b", 2, 42); pop_one();
        head("t4c", 3, 43); pop_one();
        head("t4d", 0, 50); pop_one();
        check("t4_empty", int'(bus.avg_valid), 0);

        // bad channel leaves counters and FIFO alone
        put(0, 100); put(0, 100); put(0, 100);
        put(5, 200);
        check("t5_bad", int'(bus.bad_ch), 1);
        check("t5_nopush", int'(bus.avg_valid), 0);
        put(0, 100);
        head("t5", 0, 100);
        pop_one();
        bus.flag_clr = 1'b1;
        put(6, 1);
        bus.flag_clr = 1'b0;
        check("t5_setwins", int'(bus.bad_ch), 1);
        bus.flag_clr = 1'b1;
        @(negedge clk);
        bus.flag_clr = 1'b0;
        check("t5_clr", int'(bus.bad_ch), 0);

        // asynchronous reset mid-window
        window(1, 60);
        put(0, 200); put(0, 200); put(0, 200);
        check("t6_pre", int'(bus.avg_valid), 1);
        #1 rst = 1'b1;
        #1;
        check("t6_async_valid", int'(bus.avg_valid), 0);
        check("t6_async_data", int'(bus.avg_data), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        window(0, 20);
        head("t6", 0, 20);
        pop_one();
        check("t6_empty", int'(bus.avg_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
